// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
// Sizes the length field and clamps requested lengths to the pattern register.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } tx_state_t;

  function automatic int len_w(input int width);
    return $clog2(width + 1);
  endfunction

  // A request longer than the register sends the whole register.
  function automatic int clamp_len(input int len, input int width);
    return (len > width) ? width : len;
  endfunction

endpackage

// File: rtl/bit_period_counter.sv
// Bit-period timer: pulses tick on the last clock of each enabled bit period.
// Counts down from BIT_CYCLES-1 and reloads itself on terminal count.
module bit_period_counter #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  if (BIT_CYCLES == 1) begin : g_single
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, clear};
    assign tick          = en;
  end else begin : g_count
    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] LOAD = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = LOAD;
      end else if (en) begin
        cnt_d = (cnt_q == '0) ? LOAD : cnt_q - CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= LOAD;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign tick = en && (cnt_q == '0);
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: takes a parallel pattern over valid/ready and
// shifts its low len_in bits MSB-first onto p1, ending each frame with a done pulse.
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   BIT_CYCLES = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic [len_w(WIDTH)-1:0]    len_in,
  input  logic                       valid,
  output logic                       ready,
  output logic                       p1,
  output logic                       busy,
  output logic                       done
);

  localparam int LEN_W = len_w(WIDTH);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0] bitcnt_q, bitcnt_d;
  logic [LEN_W-1:0] len_c;
  logic             p1_q, p1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             period_clear;
  logic             period_en;
  logic             tick;

  assign ready  = (state_q == IDLE) && !reset;
  assign accept = valid && ready;
  assign len_c  = LEN_W'(clamp_len(int'(len_in), WIDTH));

  bit_period_counter #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_period (
    .clk  (clk),
    .reset(reset),
    .clear(period_clear),
    .en   (period_en),
    .tick (tick)
  );

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    period_clear = 1'b0;
    period_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // Left-align so the first bit to send always sits at the MSB.
          shreg_d      = data_in << (WIDTH - int'(len_c));
          bitcnt_d     = len_c;
          period_clear = 1'b1;
          state_d      = (len_c == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        period_en = 1'b1;
        if (tick) begin
          shreg_d  = shreg_q << 1;
          bitcnt_d = bitcnt_q - LEN_W'(1);
          if (bitcnt_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    p1_d   = (state_d == SHIFT) ? shreg_d[WIDTH-1] : IDLE_LEVEL;
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      p1_q     <= IDLE_LEVEL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      p1_q     <= p1_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign p1   = p1_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial pattern transmitter: accepts a parallel bit pattern over a valid/ready handshake and drives it MSB-first onto a single-bit serial line, one bit every `BIT_CYCLES` clocks. It is the driving end of the single-bit serial input (`p1`) consumed by the team's Moore/Mealy sequence-detector FSMs. It replaces hand-written `#10 p1=...` stimulus with a synthesizable source, usable on-board and in benches. A one-cycle `done` pulse marks the end of each frame.

## Interface
- `WIDTH`, 8: maximum pattern length in bits (≥1).
- `BIT_CYCLES`, 1: clocks each bit is held on `p1` (≥1).
- `IDLE_LEVEL`, 1'b0: value of `p1` when no frame is being sent.
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: synchronous, active-high reset.
- `data_in` in WIDTH: pattern; the low `len_in` bits are sent, bit `len_in-1` first.
- `len_in` in $clog2(WIDTH+1): number of bits to send, 0..WIDTH; values >WIDTH clamp to WIDTH.
- `valid` in 1: request to send `data_in`/`len_in`.
- `ready` out 1: block can accept; `ready = (state==IDLE) && !reset`.
- `p1` out 1: serial output, registered.
- `busy` out 1: high in SHIFT and DONE, registered.
- `done` out 1: one-cycle pulse in the DONE state, registered.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `p1=IDLE_LEVEL`, `busy=0`, `done=0`.
  - Accept on a rising edge with `valid && ready`.
  - On accept, capture the pattern left-aligned: `shreg = data_in << (WIDTH-len)`.
  - Load the bit counter with `len`. Clear the period counter.
  - `len==0`: go to DONE. Otherwise go to SHIFT.
- SHIFT: `p1 = shreg[WIDTH-1]`.
  - The period counter counts 0..BIT_CYCLES-1.
  - At terminal count: shift `shreg` left by 1 (zero fill), decrement the bit counter, clear the period counter.
  - When the last bit's period ends, go to DONE.
- DONE: lasts one cycle. `done=1`, `p1=IDLE_LEVEL`, `busy=1`, `ready=0`. Then go to IDLE.
- While not in IDLE:
  - `valid` is ignored.
  - `data_in`/`len_in` may change freely; the captured copy is used.
- Reset, including mid-frame: next state IDLE, `p1=IDLE_LEVEL`, `busy=0`, `done=0`, counters and `shreg` cleared. The partial frame is abandoned and no `done` is issued.
- `valid` asserted in the same cycle as `reset` is not accepted.

## Timing
- Reset values: `p1=IDLE_LEVEL`, `busy=0`, `done=0`. `ready=1` from the first cycle after `reset` deasserts.
- Accept at edge k:
  - First bit on `p1` from edge k+1.
  - Bit i (0-based) is held for edges k+1+i·BIT_CYCLES through k+(i+1)·BIT_CYCLES.
- Last bit is followed by `done=1` for exactly one cycle, starting at edge k+1+len·BIT_CYCLES.
- `ready` returns one cycle after `done`.
- Minimum gap between back-to-back frames: 2 cycles at `IDLE_LEVEL` (DONE cycle plus the IDLE accept cycle).
- `len==0`: `done` at edge k+1, with no bits sent.
- Frame length in cycles from accept to `done`: `len·BIT_CYCLES + 1`.

## Structure
- Package `serial_tx_pkg`:
  - state enum `tx_state_t {IDLE, SHIFT, DONE}`;
  - localparam `LEN_W = $clog2(WIDTH+1)` helper function;
  - length-clamp function.
- Sub-module `bit_period_counter`:
  - parameter `BIT_CYCLES`;
  - inputs `clk`, `reset`, `clear`, `en`;
  - output `tick`, high on terminal count;
  - collapses to constant `tick=en` when `BIT_CYCLES==1`.
- Top level: FSM, shift register, bit counter, output registers.

## Test plan
- Basic frame, WIDTH=8, BIT_CYCLES=1, `data_in=8'b1101_0011`, `len_in=8`, accepted at edge k -> `p1` reads 1,1,0,1,0,0,1,1 on edges k+1..k+8; `done=1` only at k+9; `ready=1` at k+10.
- Short frame, `data_in=8'hFF`, `len_in=3` -> `p1` reads 1,1,1 for 3 cycles, then `IDLE_LEVEL`; `done` at k+4.
- Stretched bits, BIT_CYCLES=4, `data_in=8'b0000_0101`, `len_in=3` -> `p1` is 1 for 4 cycles, 0 for 4 cycles, 1 for 4 cycles; `done` at k+13.
- Zero/oversize length:
  - `len_in=0` -> no bits sent, `done` at k+1.
  - `len_in=15` with WIDTH=8 -> exactly 8 bits sent.
- Handshake: hold `valid=1` continuously with two patterns (A then B) -> B is accepted only on the edge after A's DONE cycle; exactly 2 idle-level cycles separate the frames; `valid` changes during SHIFT have no effect.
- Reset mid-frame: assert `reset` at bit 3 of an 8-bit frame -> the following cycle has `p1=IDLE_LEVEL`, `busy=0`, and no `done` pulse ever occurs for that frame; a new frame sends correctly afterwards.
